// File: rtl/gate_stream_acc.sv
// Streaming bitwise two-input gate with per-frame XOR fold into a checksum word plus parity.
// Operand beats enter via valid/ready; one folded result per DEPTH beats leaves via valid/ready.
module gate_stream_acc #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_parity,
    output logic [CNT_W-1:0] frame_count
);

    // state  | meaning
    // S_IDLE | no frame in progress, next beat starts a frame and latches mode
    // S_ACC  | frame in progress, folding beats with the latched mode
    // S_HOLD | frame result presented on out_sum, waiting for out_ready
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    // cnt only ever holds 0..DEPTH-1; it is zeroed when the frame completes
    localparam int BEAT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DEPTH - 1);

    state_e             state_q, state_d;
    logic [BEAT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [1:0]         mode_q, mode_d;
    logic [CNT_W-1:0]   frame_count_q, frame_count_d;

    logic               accept;
    logic               handshake;
    logic [WIDTH-1:0]   beat_first;
    logic [WIDTH-1:0]   beat_next;

    function automatic logic [WIDTH-1:0] gate_fn(input logic [1:0] m,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        case (m)
            2'b00:   r = x ^ y;
            2'b01:   r = ~(x ^ y);
            2'b10:   r = ~x & y;
            default: r = x & ~y;
        endcase
        return r;
    endfunction

    assign in_ready    = rst_n && (state_q != S_HOLD);
    assign out_valid   = (state_q == S_HOLD);
    assign out_sum     = sum_q;
    assign out_parity  = ^sum_q;
    assign frame_count = frame_count_q;

    assign accept     = in_valid & in_ready;
    assign handshake  = out_valid & out_ready;
    assign beat_first = gate_fn(mode, a, b);
    assign beat_next  = acc_q ^ gate_fn(mode_q, a, b);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        sum_d         = sum_q;
        mode_d        = mode_q;
        frame_count_d = frame_count_q;

        if (clear) begin
            // clear wins over any coincident beat or result handshake
            state_d = S_IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        mode_d = mode;
                        acc_d  = beat_first;
                        if (DEPTH == 1) begin
                            state_d = S_HOLD;
                            sum_d   = beat_first;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_ACC;
                            cnt_d   = BEAT_W'(1);
                        end
                    end
                end
                S_ACC: begin
                    if (accept) begin
                        acc_d = beat_next;
                        if (cnt_q == LAST_BEAT) begin
                            state_d = S_HOLD;
                            sum_d   = beat_next;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + BEAT_W'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (handshake) begin
                        state_d       = S_IDLE;
                        acc_d         = '0;
                        frame_count_d = frame_count_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            acc_q         <= '0;
            sum_q         <= '0;
            mode_q        <= 2'b00;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            sum_q         <= sum_d;
            mode_q        <= mode_d;
            frame_count_q <= frame_count_d;
        end
    end

endmodule

// File: doc/gate_stream_acc.md
Name: gate_stream_acc

Overview:
- Streaming, parametrised successor to the two-input XOR gate cells.
- Each accepted beat applies a selectable bitwise two-input function to WIDTH-bit operands a and b.
- The per-beat results are XOR-folded over a frame of DEPTH beats into one checksum word plus a parity bit, returned through a valid/ready output handshake.
- Sits between operand producers and the checksum/verification consumers of the gate library.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
DEPTH, 4, beats per frame (>=1)
CNT_W, 16, width of the completed-frame counter

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
clear  input  1  synchronous abort of current frame/pending result
mode  input  2  per-beat function: 00 a^b, 01 ~(a^b), 10 ~a&b, 11 a&~b
in_valid  input  1  operand beat offered
in_ready  output  1  block can accept a beat
a  input  WIDTH  operand a
b  input  WIDTH  operand b
out_valid  output  1  frame result available
out_ready  input  1  consumer takes result
out_sum  output  WIDTH  XOR fold of the DEPTH per-beat results
out_parity  output  1  reduction XOR of out_sum
frame_count  output  CNT_W  completed (handshaken) frames, wraps

Behaviour:
- Reset (rst_n=0 at clock edge): state=IDLE, beat counter=0, accumulator=0, out_valid=0, out_sum=0, out_parity=0, frame_count=0, latched mode=00. in_ready=0 while rst_n=0. Reset overrides clear and all handshakes.
- Beat accept = in_valid & in_ready at a rising edge. Output handshake = out_valid & out_ready at a rising edge.
- in_ready=1 in IDLE and ACC; 0 in HOLD and during reset. out_valid=1 only in HOLD.
- IDLE, on accept:
  - Latch mode and set acc = f(a,b), cnt=1.
  - If DEPTH==1, go to HOLD; otherwise go to ACC.
- ACC, on accept:
  - acc = acc ^ f_latched(a,b); cnt++.
  - Accepting beat number DEPTH: go to HOLD.
  - The mode input is ignored after the first beat of a frame.
- HOLD:
  - out_sum=acc and out_parity=^acc, both stable until the handshake.
  - On output handshake: go to IDLE, out_valid=0 next cycle, frame_count+1 (wraps 2^CNT_W-1 -> 0).
  - No beat is accepted in the handshake cycle.
- Latency: out_valid rises the cycle after the last beat is accepted. Minimum frame period with out_ready=1 is DEPTH+1 cycles.
- No-valid cycles inside a frame hold state; no timeout.
- clear=1 at an edge (rst_n=1):
  - Go to IDLE, cnt=0, acc=0, out_valid=0.
  - A pending HOLD result is discarded and frame_count is unchanged.
  - clear beats a simultaneous accept or handshake; that beat/result is dropped.
- out_sum and out_parity keep their last value outside HOLD. Only out_valid qualifies them.
- Counter width is clog2(DEPTH) or greater, with DEPTH==1 handled. No arithmetic other than the cnt/frame_count increments.

Test Plan:
- Reset: hold rst_n=0 two cycles with in_valid=1, out_ready=1 -> out_valid=0, out_sum=0x00, frame_count=0, in_ready=0. First cycle after release -> in_ready=1.
- XOR frame (WIDTH=8, DEPTH=4, mode=00):
  - Beats (0x0F,0xF0),(0xFF,0x00),(0xAA,0x55),(0x12,0x34), with out_ready=1.
  - out_valid=1 exactly one cycle after the 4th accept, out_sum=0xD9, out_parity=1.
  - frame_count=1 after the handshake.
- Mode latch:
  - mode=01 on the first beat (0x00,0x00), then mode=00 for three more (0x00,0x00) beats.
  - out_sum=0x00, parity=0. A result of 0xFF means the mode was not latched.
- Backpressure and other modes:
  - mode=10 frame of four (0x0F,0xFF) beats -> out_sum=0x00.
  - mode=11 frame with beats (0xF0,0x0F),(0,0),(0,0),(0,0) -> out_sum=0xF0, parity=0.
  - Hold out_ready=0 for 5 cycles while driving in_valid=1 -> out_sum stable, in_ready=0, no beats consumed.
  - Then out_ready=1 -> one handshake, frame_count increments by exactly 1.
- Clear:
  - clear after 2 of 4 beats, then a full mode=00 frame of (0x01,0x00) x4 -> out_sum=0x00 (no residue).
  - clear while in HOLD -> out_valid falls next cycle and frame_count is unchanged.
  - clear coincident with an accept -> that beat is dropped.
- Edge params: DEPTH=1 with mode=00 beat (0x3C,0x0F) -> out_valid next cycle, out_sum=0x33, parity=0.
